// File: rtl/rcb_frl_fifo_sync.sv
// rcb_frl_fifo_sync -- single-clock FIFO with registered status flags,
// occupancy count and one-cycle error pulses.
//
// Ports:
//   CLK          in   rising-edge clock for all logic
//   RST          in   synchronous active-high reset
//   DI[WIDTH]    in   write data
//   WREN         in   write request (ignored while FULL is set)
//   RDEN         in   read request (ignored while EMPTY is set)
//   DO[WIDTH]    out  read data (registered; FWFT selects its timing)
//   EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL   out  registered status flags
//   COUNT[DEPTH_LOG2+1]                    out  stored-word occupancy
//   WRERR, RDERR out  high for one cycle after a rejected request
//
// Storage is not reset; only pointers, count, flags, DO and errors are.
module rcb_frl_fifo_sync #(
  parameter int WIDTH               = 40,
  parameter int DEPTH_LOG2          = 9,
  parameter int ALMOST_FULL_OFFSET  = 128,
  parameter int ALMOST_EMPTY_OFFSET = 128,
  parameter int FWFT                = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      DI,
  input  logic                  WREN,
  input  logic                  RDEN,
  output logic [WIDTH-1:0]      DO,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOSTEMPTY,
  output logic                  ALMOSTFULL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  WRERR,
  output logic                  RDERR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_OFFSET);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - ALMOST_FULL_OFFSET);

  // Refuse to build with nonsensical geometry or thresholds.
  if (WIDTH < 1 || WIDTH > 72 || DEPTH_LOG2 < 2 ||
      ALMOST_FULL_OFFSET < 1 || ALMOST_FULL_OFFSET > DEPTH - 1 ||
      ALMOST_EMPTY_OFFSET < 1 || ALMOST_EMPTY_OFFSET > DEPTH - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_param_err
    $error("rcb_frl_fifo_sync: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             aempty_q, aempty_d;
  logic             afull_q, afull_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             wrerr_q, wrerr_d;
  logic             rderr_q, rderr_d;

  logic             wr_acc, rd_acc;
  logic             head_is_new;

  // Acceptance looks only at the registered flags, so a read cannot make
  // room for a same-edge write and a write cannot feed a same-edge read.
  assign wr_acc = WREN & ~full_q;
  assign rd_acc = RDEN & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    aempty_d = (count_d <= AE_TH);
    afull_d  = (count_d >= AF_TH);

    wrerr_d  = WREN & ~wr_acc;
    rderr_d  = RDEN & ~rd_acc;
  end

  // With a write accepted and one word left after this edge, that word is
  // the one being written now and is not yet in memory: bypass DI.
  assign head_is_new = wr_acc && (count_d == CW'(1));

  always_comb begin
    do_d = do_q;
    if (FWFT == 0) begin
      if (rd_acc) do_d = mem[rd_ptr_q];
    end else begin
      // Show the head after this edge; hold the last value once empty.
      if (count_d != '0) do_d = head_is_new ? DI : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) mem[wr_ptr_q] <= DI;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      do_q     <= '0;
      wrerr_q  <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      do_q     <= do_d;
      wrerr_q  <= wrerr_d;
      rderr_q  <= rderr_d;
    end
  end

  assign DO          = do_q;
  assign EMPTY       = empty_q;
  assign FULL        = full_q;
  assign ALMOSTEMPTY = aempty_q;
  assign ALMOSTFULL  = afull_q;
  assign COUNT       = count_q;
  assign WRERR       = wrerr_q;
  assign RDERR       = rderr_q;

endmodule

// File: tb/tb_rcb_frl_fifo_sync.sv
// Bench for rcb_frl_fifo_sync: a standard-mode and an FWFT instance share
// one stimulus stream; a queue scoreboard predicts contents, DO and flags.
module tb_rcb_frl_fifo_sync;

  localparam int W  = 40;
  localparam int DL = 4;
  localparam int D  = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [W-1:0]  DI = '0;
  logic          WREN = 1'b0;
  logic          RDEN = 1'b0;

  logic [W-1:0]  do0, do1;
  logic          em0, em1, fu0, fu1, ae0, ae1, af0, af1;
  logic          we0, we1, re0, re1;
  logic [DL:0]   cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] m_do0 = '0;
  logic [W-1:0] m_do1 = '0;
  logic         m_wrerr = 1'b0;
  logic         m_rderr = 1'b0;

  always #5 CLK = ~CLK;

  rcb_frl_fifo_sync #(.WIDTH(W), .DEPTH_LOG2(DL), .ALMOST_FULL_OFFSET(4),
                      .ALMOST_EMPTY_OFFSET(4), .FWFT(0)) u_std (
    .CLK(CLK), .RST(RST), .DI(DI), .WREN(WREN), .RDEN(RDEN), .DO(do0),
    .EMPTY(em0), .FULL(fu0), .ALMOSTEMPTY(ae0), .ALMOSTFULL(af0),
    .COUNT(cnt0), .WRERR(we0), .RDERR(re0));

  rcb_frl_fifo_sync #(.WIDTH(W), .DEPTH_LOG2(DL), .ALMOST_FULL_OFFSET(4),
                      .ALMOST_EMPTY_OFFSET(4), .FWFT(1)) u_fwft (
    .CLK(CLK), .RST(RST), .DI(DI), .WREN(WREN), .RDEN(RDEN), .DO(do1),
    .EMPTY(em1), .FULL(fu1), .ALMOSTEMPTY(ae1), .ALMOSTFULL(af1),
    .COUNT(cnt1), .WRERR(we1), .RDERR(re1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = sb.size();
    chk("std.count",  64'(cnt0), 64'(n));
    chk("std.empty",  64'(em0),  64'(n == 0));
    chk("std.full",   64'(fu0),  64'(n == D));
    chk("std.aempty", 64'(ae0),  64'(n <= 4));
    chk("std.afull",  64'(af0),  64'(n >= D - 4));
    chk("std.wrerr",  64'(we0),  64'(m_wrerr));
    chk("std.rderr",  64'(re0),  64'(m_rderr));
    chk("std.do",     64'(do0),  64'(m_do0));
    chk("fwft.count", 64'(cnt1), 64'(n));
    chk("fwft.empty", 64'(em1),  64'(n == 0));
    chk("fwft.full",  64'(fu1),  64'(n == D));
    chk("fwft.aempty",64'(ae1),  64'(n <= 4));
    chk("fwft.afull", 64'(af1),  64'(n >= D - 4));
    chk("fwft.wrerr", 64'(we1),  64'(m_wrerr));
    chk("fwft.rderr", 64'(re1),  64'(m_rderr));
    chk("fwft.do",    64'(do1),  64'(m_do1));
  endtask

  // One clock: drive inputs, predict from pre-edge occupancy, then compare.
  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input logic rs);
    int  n;
    logic wa, ra;
    WREN = w; RDEN = r; DI = d; RST = rs;
    n  = sb.size();
    wa = w && !rs && (n != D);
    ra = r && !rs && (n != 0);
    @(posedge CLK);
    #1;
    if (rs) begin
      sb.delete();
      m_do0 = '0; m_do1 = '0; m_wrerr = 1'b0; m_rderr = 1'b0;
    end else begin
      if (ra) m_do0 = sb.pop_front();
      if (wa) sb.push_back(d);
      if (sb.size() != 0) m_do1 = sb[0];
      else if (ra)        m_do1 = m_do0;
      m_wrerr = w && !wa;
      m_rderr = r && !ra;
    end
    check_all();
  endtask

  initial begin
    // reset, with WREN/RDEN asserted to show reset wins
    cyc(1'b1, 1'b1, 40'h99, 1'b1);
    cyc(1'b1, 1'b0, 40'h98, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // fill to full, then overflow attempt
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, W'(i), 1'b0);
    cyc(1'b1, 1'b0, 40'h11, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // drain, then underflow attempt (DO holds 0x10)
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // steady state at COUNT 8, pointers wrap twice
    for (int i = 0; i < 8; i++)  cyc(1'b1, 1'b0, W'(40'h100 + i), 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, W'(40'h200 + i), 1'b0);

    // simultaneous read/write at full and at empty
    for (int i = 0; i < 8; i++)  cyc(1'b1, 1'b0, W'(40'h280 + i), 1'b0);
    cyc(1'b1, 1'b1, 40'h300, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b1, 1'b1, 40'h400, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);

    // FWFT write-to-visible and pop-to-next
    cyc(1'b1, 1'b0, 40'hAA, 1'b0);
    cyc(1'b1, 1'b0, 40'hBB, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);

    // reset mid-operation at COUNT 10
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, W'(40'h500 + i), 1'b0);
    cyc(1'b1, 1'b0, 40'h77, 1'b1);
    cyc(1'b1, 1'b0, 40'h55, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);

    // random traffic
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {8'h0, 32'($urandom)}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rcb_frl_fifo_sync.md
RCB_FRL_FIFO_SYNC -- requirements
Module: rcb_frl_fifo_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 40, data word width in bits (1..72).
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 (DEPTH_LOG2 >= 2).
REQ-003 SHALL have parameter ALMOST_FULL_OFFSET, default 128, ALMOSTFULL threshold distance from full (1..DEPTH-1).
REQ-004 SHALL have parameter ALMOST_EMPTY_OFFSET, default 128, ALMOSTEMPTY threshold distance from empty (1..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, 1 = first-word-fall-through read mode, 0 = standard read mode.
REQ-006 SHALL have port CLK  input  1  single clock for all logic, rising edge.
REQ-007 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port DI  input  WIDTH  write data.
REQ-009 SHALL have port WREN  input  1  write request.
REQ-010 SHALL have port RDEN  input  1  read request.
REQ-011 SHALL have port DO  output  WIDTH  read data.
REQ-012 SHALL have ports EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL  output  1 each  status flags.
REQ-013 SHALL have port COUNT  output  DEPTH_LOG2+1  stored-word occupancy.
REQ-014 SHALL have ports WRERR, RDERR  output  1 each  one-cycle error pulses.

Function
REQ-015 Write accepted iff WREN=1 and FULL=1 not registered at that edge; accepted word stored at write pointer, pointer +1.
REQ-016 Read accepted iff RDEN=1 and EMPTY=0 at that edge; read pointer +1.
REQ-017 Acceptance uses registered flags only: write while FULL rejected even with simultaneous accepted read; read while EMPTY rejected even with simultaneous write.
REQ-018 Pointers are DEPTH_LOG2 bits, wrap modulo DEPTH with no gap or lost word.
REQ-019 COUNT: +1 write-only accept, -1 read-only accept, unchanged for both or neither; range 0..DEPTH.
REQ-020 Flags registered, updated same edge as COUNT from next-count: EMPTY=(COUNT==0), FULL=(COUNT==DEPTH), ALMOSTEMPTY=(COUNT<=ALMOST_EMPTY_OFFSET), ALMOSTFULL=(COUNT>=DEPTH-ALMOST_FULL_OFFSET).
REQ-021 WRERR high exactly the cycle after a rejected write request; RDERR likewise for rejected read; otherwise 0.
REQ-022 FWFT=0: accepted read at edge N presents word on DO after edge N (1-cycle latency); DO holds last read word when no read accepted.
REQ-023 FWFT=1: DO shows oldest stored word whenever EMPTY=0; accepted read pops it and DO shows next word after same edge; DO value undefined-but-stable-held while EMPTY=1 (holds last popped word).
REQ-024 FWFT=1: first write into empty FIFO -> EMPTY=0 and word on DO after that edge (1-cycle write-to-visible).
REQ-025 Storage content not cleared by reset; only pointers, COUNT, flags, DO, errors reset.
REQ-026 Parameter violations (offsets out of range, DEPTH_LOG2<2) SHALL halt elaboration.

Reset
REQ-027 RST=1 at an edge SHALL force: pointers 0, COUNT 0, EMPTY 1, ALMOSTEMPTY 1, FULL 0, ALMOSTFULL 0, DO 0, WRERR 0, RDERR 0.
REQ-028 RST SHALL take precedence over WREN/RDEN at the same edge; no write/read accepted, no error pulse.
REQ-029 Reset mid-operation discards all stored words; first write after reset lands at address 0.

Verification (DEPTH_LOG2=4, offsets=4, WIDTH=40)
REQ-030 Reset, write 16 words 0x01..0x10 -> COUNT 16, FULL=1, ALMOSTFULL from COUNT 12, ALMOSTEMPTY cleared at COUNT 5; 17th write -> WRERR pulse, COUNT stays 16.
REQ-031 FWFT=0, read 16 -> DO=0x01..0x10 each one cycle after RDEN; EMPTY=1 after 16th; extra RDEN -> RDERR pulse, DO stays 0x10.
REQ-032 COUNT 8, WREN+RDEN together 40 cycles with incrementing data -> COUNT stays 8, in-order data, pointers wrap twice without loss.
REQ-033 FULL with WREN+RDEN same edge -> read accepted, WRERR=1, COUNT 15; EMPTY with both -> write accepted, RDERR=1, COUNT 1.
REQ-034 FWFT=1, write 0xAA into empty -> next cycle EMPTY=0, DO=0xAA; RDEN with second word 0xBB stored -> DO=0xBB after edge.
REQ-035 RST asserted at COUNT 10 with WREN=1 -> COUNT 0, EMPTY 1, DO 0; next write 0x55 then read returns 0x55.
